// File: rtl/stage_decode_sb_pkg.sv
// stage_decode_sb_pkg: shared RV32I opcodes, ALU op codes, format one-hots and decode control bundle.
package stage_decode_sb_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Base ops follow funct3; M-extension ops are {1'b1, funct3}. NOP is an add to x0.
    localparam logic [3:0] ALUOP_ADD    = 4'd0;
    localparam logic [3:0] ALUOP_SLL    = 4'd1;
    localparam logic [3:0] ALUOP_SLT    = 4'd2;
    localparam logic [3:0] ALUOP_SLTU   = 4'd3;
    localparam logic [3:0] ALUOP_XOR    = 4'd4;
    localparam logic [3:0] ALUOP_SR     = 4'd5;
    localparam logic [3:0] ALUOP_OR     = 4'd6;
    localparam logic [3:0] ALUOP_AND    = 4'd7;
    localparam logic [3:0] ALUOP_MUL    = 4'd8;
    localparam logic [3:0] ALUOP_MULH   = 4'd9;
    localparam logic [3:0] ALUOP_MULHSU = 4'd10;
    localparam logic [3:0] ALUOP_MULHU  = 4'd11;
    localparam logic [3:0] ALUOP_DIV    = 4'd12;
    localparam logic [3:0] ALUOP_DIVU   = 4'd13;
    localparam logic [3:0] ALUOP_REM    = 4'd14;
    localparam logic [3:0] ALUOP_REMU   = 4'd15;
    localparam logic [3:0] ALUOP_NOP    = ALUOP_ADD;

    typedef logic [5:0] fmt_t;
    localparam fmt_t FMT_R = 6'b000001;
    localparam fmt_t FMT_I = 6'b000010;
    localparam fmt_t FMT_S = 6'b000100;
    localparam fmt_t FMT_B = 6'b001000;
    localparam fmt_t FMT_U = 6'b010000;
    localparam fmt_t FMT_J = 6'b100000;

    typedef struct packed {
        logic [3:0] op;
        logic       use_pc0;
        logic       use_pc1;
        logic       use_imm;
        logic       sub_sra;
        logic       mem_read;
        logic       mem_write;
        logic       mem_extend;
        logic [1:0] mem_width;
        logic       mem_jmp;
        logic       mem_br;
        logic       mem_br_inv;
    } ctl_t;

endpackage

// File: rtl/stage_decode_sb_if.sv
// stage_decode_sb_if: fetch, writeback and execute-side signals of the decode stage.
interface stage_decode_sb_if #(parameter int XLEN = 32);
    logic            de_valid;
    logic [31:0]     de_insn;
    logic [XLEN-1:0] de_pc;
    logic            de_stall;
    logic            ex_stall;
    logic            flush;
    logic [4:0]      wb_wreg;
    logic [XLEN-1:0] wb_wdata;
    logic            wb_wen;
    logic            ex_valid;
    logic            ex_illegal;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rdata1;
    logic [XLEN-1:0] ex_rdata2;
    logic [XLEN-1:0] ex_imm;
    logic [3:0]      ex_op;
    logic            ex_use_pc0;
    logic            ex_use_pc1;
    logic            ex_use_imm;
    logic            ex_sub_sra;
    logic            mem_read;
    logic            mem_write;
    logic            mem_extend;
    logic [1:0]      mem_width;
    logic            mem_jmp;
    logic            mem_br;
    logic            mem_br_inv;
    logic [4:0]      wb_reg;

    modport master (
        output de_valid, de_insn, de_pc, ex_stall, flush, wb_wreg, wb_wdata, wb_wen,
        input  de_stall, ex_valid, ex_illegal, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_op,
               ex_use_pc0, ex_use_pc1, ex_use_imm, ex_sub_sra, mem_read, mem_write,
               mem_extend, mem_width, mem_jmp, mem_br, mem_br_inv, wb_reg
    );
    modport slave (
        input  de_valid, de_insn, de_pc, ex_stall, flush, wb_wreg, wb_wdata, wb_wen,
        output de_stall, ex_valid, ex_illegal, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_op,
               ex_use_pc0, ex_use_pc1, ex_use_imm, ex_sub_sra, mem_read, mem_write,
               mem_extend, mem_width, mem_jmp, mem_br, mem_br_inv, wb_reg
    );
endinterface

// File: rtl/stage_decode_sb_decode_scoreboard.sv
// decode_scoreboard: per-register outstanding-write counters, operand readiness and writeback bypass select.
module decode_scoreboard #(
    parameter int SB_W = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       writes_rd_i,
    input  logic       issue_i,
    input  logic       wb_wen_i,
    input  logic [4:0] wb_wreg_i,
    input  logic       rel_i,
    input  logic [4:0] rel_reg_i,
    output logic       hazard_o,
    output logic       byp1_o,
    output logic       byp2_o
);
    logic [SB_W-1:0] cnt_q [32];
    logic [SB_W-1:0] cnt_d [32];
    logic            rdy1, rdy2;

    // Issue, writeback and squash release all fold into one net update per register.
    always_comb begin
        for (int i = 0; i < 32; i++)
            cnt_d[i] = (i == 0) ? '0 : cnt_q[i] + SB_W'(issue_i && rd_i == 5'(i))
                                                - SB_W'(wb_wen_i && wb_wreg_i == 5'(i))
                                                - SB_W'(rel_i && rel_reg_i == 5'(i));
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '{default: '0};
        else cnt_q <= cnt_d;

    assign byp1_o   = wb_wen_i && wb_wreg_i == rs1_i && rs1_i != 5'd0;
    assign byp2_o   = wb_wen_i && wb_wreg_i == rs2_i && rs2_i != 5'd0;
    assign rdy1     = rs1_i == 5'd0 || cnt_q[rs1_i] == '0 || (cnt_q[rs1_i] == SB_W'(1) && byp1_o);
    assign rdy2     = rs2_i == 5'd0 || cnt_q[rs2_i] == '0 || (cnt_q[rs2_i] == SB_W'(1) && byp2_o);
    assign hazard_o = !rdy1 || !rdy2 || (writes_rd_i && rd_i != 5'd0 && cnt_q[rd_i] == '1);
endmodule

// File: rtl/stage_decode_sb.sv
// stage_decode_sb: RV32I decode stage with register file and scoreboard hazard detection.
// Define DECODE_MULDIV_EN to decode the M-extension (OP with funct7=0000001).
module stage_decode_sb
    import stage_decode_sb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SB_W = 2
) (
    input logic              clk,
    input logic              reset_n,
    stage_decode_sb_if.slave bus
);
    logic [31:0]     insn;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    fmt_t            fmt;
    ctl_t            ctl, ex_ctl_q;
    logic            legal, u1, u2, writes_rd, hazard, byp1, byp2, issue, ex_valid_d;
    logic [4:0]      rs1, rs2, rd, wb_reg_q;
    logic [XLEN-1:0] imm, rdata1, rdata2, rf_q [32];
    logic [XLEN-1:0] ex_pc_q, ex_rdata1_q, ex_rdata2_q, ex_imm_q;
    logic            ex_valid_q, ex_illegal_q;

    assign insn = bus.de_insn;
    assign opc  = insn[6:0];
    assign f3   = insn[14:12];
    assign f7   = insn[31:25];

    always_comb begin
        ctl = '0; fmt = '0; legal = 1'b0; u1 = 1'b0; u2 = 1'b0;
        case (opc)
            OP_LUI:    begin fmt = FMT_U; legal = 1'b1; ctl.use_imm = 1'b1; end
            OP_AUIPC:  begin fmt = FMT_U; legal = 1'b1; ctl.use_imm = 1'b1; ctl.use_pc0 = 1'b1; end
            OP_JAL: begin
                fmt = FMT_J; legal = 1'b1; ctl.use_imm = 1'b1;
                ctl.use_pc0 = 1'b1; ctl.use_pc1 = 1'b1; ctl.mem_jmp = 1'b1;
            end
            OP_JALR:   begin fmt = FMT_I; legal = f3 == 3'd0; u1 = 1'b1; ctl.use_imm = 1'b1; ctl.mem_jmp = 1'b1; end
            OP_BRANCH: begin
                fmt = FMT_B; legal = f3[2:1] != 2'b01; u1 = 1'b1; u2 = 1'b1;
                ctl.use_pc1 = 1'b1; ctl.mem_br = 1'b1; ctl.mem_br_inv = f3[0];
                ctl.op = f3[2] ? (f3[1] ? ALUOP_SLTU : ALUOP_SLT) : ALUOP_ADD;
                ctl.sub_sra = !f3[2];
            end
            OP_LOAD: begin
                fmt = FMT_I; legal = f3 != 3'd7 && (XLEN == 64 || (f3[1:0] != 2'b11 && f3 != 3'd6));
                u1 = 1'b1; ctl.use_imm = 1'b1; ctl.mem_read = 1'b1;
                ctl.mem_width = f3[1:0]; ctl.mem_extend = !f3[2];
            end
            OP_STORE: begin
                fmt = FMT_S; legal = !f3[2] && (XLEN == 64 || f3[1:0] != 2'b11);
                u1 = 1'b1; u2 = 1'b1; ctl.use_imm = 1'b1; ctl.mem_write = 1'b1; ctl.mem_width = f3[1:0];
            end
            OP_IMM: begin
                fmt = FMT_I; u1 = 1'b1; ctl.use_imm = 1'b1; ctl.op = {1'b0, f3};
                legal = f3 == 3'd1 ? f7 == 7'd0 : f3 == 3'd5 ? (f7 & 7'b1011111) == 7'd0 : 1'b1;
                ctl.sub_sra = f3 == 3'd5 && insn[30];
            end
            OP_OP: begin
                fmt = FMT_R; u1 = 1'b1; u2 = 1'b1; ctl.op = {f7[0], f3}; ctl.sub_sra = f7[5];
                legal = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))
`ifdef DECODE_MULDIV_EN
                        || f7 == 7'b0000001
`endif
                        ;
            end
            default: ;
        endcase
        // Illegal instructions flow down as a NOP with no operands and no destination.
        if (!legal) begin
            ctl = '0; fmt = '0; u1 = 1'b0; u2 = 1'b0;
        end
    end

    assign writes_rd = legal && opc != OP_BRANCH && opc != OP_STORE;
    assign rs1 = u1 ? insn[19:15] : 5'd0;
    assign rs2 = u2 ? insn[24:20] : 5'd0;
    assign rd  = writes_rd ? insn[11:7] : 5'd0;
    assign imm = fmt == FMT_I ? XLEN'($signed(insn[31:20]))
               : fmt == FMT_S ? XLEN'($signed({insn[31:25], insn[11:7]}))
               : fmt == FMT_B ? XLEN'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}))
               : fmt == FMT_U ? XLEN'($signed({insn[31:12], 12'b0}))
               : fmt == FMT_J ? XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}))
               : '0;

    decode_scoreboard #(.SB_W(SB_W)) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rd_i        (rd),
        .writes_rd_i (writes_rd),
        .issue_i     (issue),
        .wb_wen_i    (bus.wb_wen),
        .wb_wreg_i   (bus.wb_wreg),
        .rel_i       (bus.flush && ex_valid_q && !ex_illegal_q),
        .rel_reg_i   (wb_reg_q),
        .hazard_o    (hazard),
        .byp1_o      (byp1),
        .byp2_o      (byp2)
    );

    assign bus.de_stall = bus.de_valid && !bus.flush && (bus.ex_stall || hazard);
    assign issue        = bus.de_valid && !bus.de_stall && !bus.flush && writes_rd;
    assign rdata1       = byp1 ? bus.wb_wdata : rs1 == 5'd0 ? '0 : rf_q[rs1];
    assign rdata2       = byp2 ? bus.wb_wdata : rs2 == 5'd0 ? '0 : rf_q[rs2];
    assign ex_valid_d   = bus.flush ? 1'b0 : bus.ex_stall ? ex_valid_q : bus.de_valid && !hazard;

    always_ff @(posedge clk)
        if (bus.wb_wen && bus.wb_wreg != 5'd0) rf_q[bus.wb_wreg] <= bus.wb_wdata;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_pc_q      <= '0;
            ex_rdata1_q  <= '0;
            ex_rdata2_q  <= '0;
            ex_imm_q     <= '0;
            ex_ctl_q     <= '0;
            wb_reg_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (!bus.ex_stall) begin
                ex_illegal_q <= bus.de_valid && !bus.flush && !legal;
                ex_pc_q      <= bus.de_pc;
                ex_rdata1_q  <= rdata1;
                ex_rdata2_q  <= rdata2;
                ex_imm_q     <= imm;
                ex_ctl_q     <= ctl;
                wb_reg_q     <= rd;
            end
        end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_illegal = ex_illegal_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_rdata1  = ex_rdata1_q;
    assign bus.ex_rdata2  = ex_rdata2_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_op      = ex_ctl_q.op;
    assign bus.ex_use_pc0 = ex_ctl_q.use_pc0;
    assign bus.ex_use_pc1 = ex_ctl_q.use_pc1;
    assign bus.ex_use_imm = ex_ctl_q.use_imm;
    assign bus.ex_sub_sra = ex_ctl_q.sub_sra;
    assign bus.mem_read   = ex_ctl_q.mem_read;
    assign bus.mem_write  = ex_ctl_q.mem_write;
    assign bus.mem_extend = ex_ctl_q.mem_extend;
    assign bus.mem_width  = ex_ctl_q.mem_width;
    assign bus.mem_jmp    = ex_ctl_q.mem_jmp;
    assign bus.mem_br     = ex_ctl_q.mem_br;
    assign bus.mem_br_inv = ex_ctl_q.mem_br_inv;
    assign bus.wb_reg     = wb_reg_q;
endmodule

// File: tb/tb_stage_decode_sb.sv
// tb_stage_decode_sb: directed self-checking bench for stage_decode_sb (honours DECODE_MULDIV_EN).
module tb_stage_decode_sb;
    import stage_decode_sb_pkg::*;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADD_X2  = 32'h00108133;
    localparam logic [31:0] ADDI_X3 = 32'h00100193;
    localparam logic [31:0] LUI_X4  = 32'h12345237;
    localparam logic [31:0] ADD_X5  = 32'h004202B3;
    localparam logic [31:0] MUL_X5  = 32'h027302B3;
    localparam logic [31:0] SW_X2   = 32'h0020A423;
    localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    stage_decode_sb_if #(.XLEN(32)) bus ();

    stage_decode_sb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic st, input logic fl,
                         input logic wen, input logic [4:0] wreg, input logic [31:0] wdata);
        @(negedge clk);
        bus.de_valid = v;
        bus.de_insn  = insn;
        bus.ex_stall = st;
        bus.flush    = fl;
        bus.wb_wen   = wen;
        bus.wb_wreg  = wreg;
        bus.wb_wdata = wdata;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.de_valid = 1'b0; bus.de_insn = '0; bus.de_pc = '0; bus.ex_stall = 1'b0;
        bus.flush = 1'b0; bus.wb_wen = 1'b0; bus.wb_wreg = '0; bus.wb_wdata = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_illegal", 32'(bus.ex_illegal), 32'd0);
        chk("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("rst_ex_imm", bus.ex_imm, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // RAW on x1 resolved by same-cycle writeback bypass
        drive(1, ADDI_X1, 0, 0, 0, 0, 0);
        chk("addi_stall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("addi_valid", 32'(bus.ex_valid), 32'd1);
        chk("addi_imm", bus.ex_imm, 32'd5);
        chk("addi_wb_reg", 32'(bus.wb_reg), 32'd1);
        chk("addi_use_imm", 32'(bus.ex_use_imm), 32'd1);
        drive(1, ADD_X2, 0, 0, 0, 0, 0);
        chk("raw_stall", 32'(bus.de_stall), 32'd1);
        tick;
        chk("raw_bubble", 32'(bus.ex_valid), 32'd0);
        drive(1, ADD_X2, 0, 0, 1, 5'd1, 32'd5);
        chk("byp_nostall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("byp_valid", 32'(bus.ex_valid), 32'd1);
        chk("byp_rdata1", bus.ex_rdata1, 32'd5);
        chk("byp_rdata2", bus.ex_rdata2, 32'd5);
        chk("byp_wb_reg", 32'(bus.wb_reg), 32'd2);

        // Saturating x3 counter
        for (int i = 0; i < 3; i++) begin
            drive(1, ADDI_X3, 0, 0, 0, 0, 0);
            chk("x3_issue", 32'(bus.de_stall), 32'd0);
            tick;
        end
        drive(1, ADDI_X3, 0, 0, 0, 0, 0);
        chk("x3_full_stall", 32'(bus.de_stall), 32'd1);
        tick;
        chk("x3_full_bubble", 32'(bus.ex_valid), 32'd0);
        drive(1, ADDI_X3, 0, 0, 1, 5'd3, 32'd7);
        chk("x3_wb_cycle_stall", 32'(bus.de_stall), 32'd1);
        tick;
        drive(1, ADDI_X3, 0, 0, 0, 0, 0);
        chk("x3_after_wb", 32'(bus.de_stall), 32'd0);
        tick;
        chk("x3_valid", 32'(bus.ex_valid), 32'd1);
        chk("x3_wb_reg", 32'(bus.wb_reg), 32'd3);
        drive(0, 0, 0, 0, 1, 5'd2, 32'd10);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 5'd3, 32'd7);
            tick;
        end

        // Flush releases the squashed x4 reservation alongside a writeback
        drive(1, LUI_X4, 0, 0, 0, 0, 0);
        tick;
        chk("lui_imm", bus.ex_imm, 32'h12345000);
        chk("lui_wb_reg", 32'(bus.wb_reg), 32'd4);
        drive(1, LUI_X4, 0, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 1, 1, 5'd4, 32'h44);
        chk("flush_stall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        drive(1, ADD_X5, 0, 0, 0, 0, 0);
        chk("x4_released", 32'(bus.de_stall), 32'd0);
        tick;
        chk("x4_rdata1", bus.ex_rdata1, 32'h44);
        chk("x4_rdata2", bus.ex_rdata2, 32'h44);
        drive(0, 0, 0, 0, 1, 5'd5, 32'h55);
        tick;

        // All-zero instruction is illegal
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        chk("ill_stall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("ill_valid", 32'(bus.ex_valid), 32'd1);
        chk("ill_flag", 32'(bus.ex_illegal), 32'd1);
        chk("ill_wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("ill_op", 32'(bus.ex_op), 32'(ALUOP_NOP));

        drive(1, MUL_X5, 0, 0, 0, 0, 0);
        tick;
`ifdef DECODE_MULDIV_EN
        chk("mul_op", 32'(bus.ex_op), 32'(ALUOP_MUL));
        chk("mul_illegal", 32'(bus.ex_illegal), 32'd0);
        chk("mul_wb_reg", 32'(bus.wb_reg), 32'd5);
        drive(0, 0, 0, 0, 1, 5'd5, 32'h0);
        tick;
`else
        chk("mul_illegal", 32'(bus.ex_illegal), 32'd1);
        chk("mul_wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("mul_op", 32'(bus.ex_op), 32'(ALUOP_NOP));
`endif

        bus.de_pc = 32'h80;
        drive(1, SW_X2, 0, 0, 0, 0, 0);
        chk("sw_stall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        chk("sw_width", 32'(bus.mem_width), 32'd2);
        chk("sw_imm", bus.ex_imm, 32'd8);
        chk("sw_rdata1", bus.ex_rdata1, 32'd5);
        chk("sw_rdata2", bus.ex_rdata2, 32'd10);
        chk("sw_wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("sw_pc", bus.ex_pc, 32'h80);

        drive(1, BEQ_M4, 0, 0, 0, 0, 0);
        tick;
        chk("beq_imm", bus.ex_imm, 32'hFFFFFFFC);
        chk("beq_br", 32'(bus.mem_br), 32'd1);
        chk("beq_pc1", 32'(bus.ex_use_pc1), 32'd1);
        chk("beq_wb_reg", 32'(bus.wb_reg), 32'd0);

        // ex_stall holds the execute register; flush overrides it
        drive(1, ADDI_X1, 1, 0, 0, 0, 0);
        chk("hold_stall", 32'(bus.de_stall), 32'd1);
        tick;
        chk("hold_imm", bus.ex_imm, 32'hFFFFFFFC);
        chk("hold_valid", 32'(bus.ex_valid), 32'd1);
        drive(1, ADDI_X1, 1, 1, 0, 0, 0);
        chk("flush_prio_stall", 32'(bus.de_stall), 32'd0);
        tick;
        chk("flush_prio_valid", 32'(bus.ex_valid), 32'd0);

        // Asynchronous reset in the middle of a hazard stall
        drive(1, ADDI_X1, 0, 0, 0, 0, 0);
        tick;
        drive(1, ADD_X2, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", 32'(bus.de_stall), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(bus.de_stall), 32'd0);
        chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("async_rst_wb_reg", 32'(bus.wb_reg), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
